// File: rtl/ysyx_24100006_fencei_ctrl.sv
// ysyx_24100006_fencei_ctrl: EXE-stage handshake wrapper that serialises fence.i around an icache flush
module ysyx_24100006_fencei_ctrl #(
  parameter int TO_W   = 8,
  parameter int TO_MAX = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        up_valid,
  output logic        up_ready,
  output logic        down_valid,
  input  logic        down_ready,
  input  logic        is_fence_i,
  input  logic        br_redirect_valid,
  input  logic [31:0] br_npc,
  input  logic [31:0] pc_add_4,
  output logic        icache_flush_req,
  input  logic        icache_flush_done,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        fence_busy,
  output logic        flush_timeout_err
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RELEASE} state_t;
  state_t          r_state, w_next;
  logic [TO_W-1:0] r_cnt;
  logic            r_req, r_err;
  logic            w_start, w_pass, w_rel, w_hs, w_timeout;
  assign w_start   = (r_state == S_IDLE) && up_valid && is_fence_i;
  assign w_pass    = (r_state == S_IDLE) && !w_start;
  assign w_rel     = (r_state == S_RELEASE);
  assign w_hs      = up_valid && down_ready;
  // a done pulse in the same cycle as the timeout takes priority, so no error
  assign w_timeout = (r_state == S_WAIT) && !icache_flush_done && (r_cnt == TO_W'(TO_MAX - 1));
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    w_next = w_start ? S_REQ : S_IDLE;
      S_REQ:     w_next = icache_flush_done ? S_RELEASE : S_WAIT;
      S_WAIT:    w_next = (icache_flush_done || w_timeout) ? S_RELEASE : S_WAIT;
      S_RELEASE: w_next = w_hs ? S_IDLE : S_RELEASE;
      default:   w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == S_WAIT) ? r_cnt + 1'b1 : '0;
      r_req   <= (w_next == S_REQ);
      r_err   <= r_err | w_timeout;
    end
  end
  assign down_valid        = (w_pass || w_rel) ? up_valid : 1'b0;
  assign up_ready          = (w_pass || w_rel) ? down_ready : 1'b0;
  assign redirect_valid    = w_rel ? w_hs : (w_pass ? br_redirect_valid : 1'b0);
  assign redirect_pc       = w_rel ? pc_add_4 : br_npc;
  assign icache_flush_req  = r_req;
  assign fence_busy        = (r_state != S_IDLE);
  assign flush_timeout_err = r_err;
endmodule

// File: doc/ysyx_24100006_fencei_ctrl.md
Name: ysyx_24100006_fencei_ctrl

Overview:
- Sequencing controller wrapped around the EXE stage handshake.
- Normally passes the ID_EXE/EXE_MEM valid/ready pair straight through, along with the branch redirect computed in EXE.
- On a fence.i instruction it:
  - applies back-pressure upstream and withholds valid downstream;
  - issues an icache flush request and waits for completion, bounded by a timeout;
  - releases the instruction with a forced redirect to pc+4, so that following instructions are refetched from the clean icache.

Parameters:
TO_W, 8, width of flush-wait timeout counter
TO_MAX, 200, wait cycles before the flush is declared complete (must be < 2^TO_W)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
up_valid  input  1  valid from ID_EXE (exe_out_valid)
up_ready  output  1  ready to ID_EXE
down_valid  output  1  valid to EXE_MEM
down_ready  input  1  ready from EXE_MEM
is_fence_i  input  1  current EXE instruction is fence.i
br_redirect_valid  input  1  branch redirect computed in EXE
br_npc  input  32  branch target computed in EXE
pc_add_4  input  32  pc+4 of current EXE instruction
icache_flush_req  output  1  one-cycle flush request pulse to icache (registered)
icache_flush_done  input  1  flush-complete pulse from icache
redirect_valid  output  1  redirect to IFU
redirect_pc  output  32  redirect target to IFU
fence_busy  output  1  controller is not in IDLE
flush_timeout_err  output  1  sticky: a flush ended by timeout

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - state = IDLE, counter = 0.
  - icache_flush_req = 0, flush_timeout_err = 0.
  - fence_busy = 0 and down_valid = up_valid (pass-through, since state is IDLE).
- Reset asserted mid-operation (REQ, WAIT or RELEASE) returns to IDLE next edge. No redirect is issued and the err flag is cleared.
- States are IDLE, REQ, WAIT and RELEASE.
- IDLE:
  - If up_valid=0 or is_fence_i=0, operate as pass-through:
    - down_valid = up_valid, up_ready = down_ready.
    - redirect_valid = br_redirect_valid, redirect_pc = br_npc.
  - If up_valid=1 and is_fence_i=1:
    - Drive down_valid=0, up_ready=0, redirect_valid=0 in this same cycle.
    - Next state is REQ.
- REQ:
  - Registered icache_flush_req is high for exactly this one cycle.
  - Stall outputs: down_valid=0, up_ready=0, redirect_valid=0.
  - Counter is cleared.
  - If icache_flush_done=1 in this cycle, go to RELEASE; otherwise go to WAIT.
- WAIT:
  - Stall outputs as in REQ; icache_flush_req=0.
  - Counter increments by 1 each cycle.
  - If icache_flush_done=1, go to RELEASE.
  - Else if counter == TO_MAX-1, set flush_timeout_err=1 and go to RELEASE.
  - If done and timeout occur in the same cycle, done wins and err is not set.
- RELEASE:
  - down_valid = up_valid, up_ready = down_ready.
  - redirect_valid = up_valid & down_ready (asserted only in the handshake cycle).
  - redirect_pc = pc_add_4; br_redirect_valid and br_npc are ignored.
  - On up_valid & down_ready, go to IDLE. Otherwise hold RELEASE, including when up_valid drops.
- Only one flush request per fence.i. A fence.i entering in the cycle after RELEASE starts a new sequence.
- icache_flush_done arriving in IDLE or RELEASE is ignored.
- fence_busy = (state != IDLE).
- Redirect compare:
  - Pass-through does not modify br_redirect_valid; EXE already suppresses pc+4-equal targets.
  - RELEASE always redirects, even when the target equals the sequential pc.
- Latency:
  - fence.i with immediate done in REQ: 3 cycles minimum from entry to handshake (IDLE, REQ, RELEASE).
  - Non-fence instructions: zero added latency.

Test Plan:
1. Non-fence pass-through:
   - Stimulus: up_valid=1, down_ready=1, br_redirect_valid=1, br_npc=0x80000100.
   - Required: down_valid=1, up_ready=1, redirect_valid=1, redirect_pc=0x80000100, fence_busy=0 in the same cycle.
2. fence.i with done 5 cycles after request:
   - Stimulus: pc_add_4=0x80000024.
   - Required: icache_flush_req high exactly 1 cycle; down_valid=0 throughout WAIT.
   - Required: after done, a RELEASE handshake with redirect_valid=1 and redirect_pc=0x80000024, then IDLE.
3. Done coincident with request:
   - Stimulus: icache_flush_done=1 in the REQ cycle.
   - Required: WAIT is skipped; RELEASE on the next cycle; flush_timeout_err=0.
4. Timeout:
   - Stimulus: TO_MAX=4, icache_flush_done never asserted.
   - Required: after 4 WAIT cycles, flush_timeout_err=1 (sticky), RELEASE entered, redirect to pc_add_4 issued.
5. Downstream back-pressure in RELEASE:
   - Stimulus: down_ready=0 for 3 cycles.
   - Required: state holds RELEASE; redirect_valid=0 until down_ready=1; then one redirect and IDLE.
6. Reset mid-WAIT:
   - Stimulus: assert reset for 1 cycle.
   - Required: next cycle state IDLE, fence_busy=0, icache_flush_req=0, flush_timeout_err=0, no redirect issued.
